// File: rtl/addsub_share_arbiter.sv
// Round-robin arbiter sharing one external ripple-carry add/sub unit between two requesters.
// Operands are held on the unit for SETTLE_CYCLES, then the result is returned on a response channel.
module addsub_share_arbiter #(
    parameter int WIDTH         = 64,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic             au_carryIn,
    input  logic [WIDTH-1:0] au_result,
    input  logic             au_carryOut,
    input  logic             au_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_overflow,
    output logic [1:0]       dbgState
);

    // Handshake rule for every channel: a transfer happens on a rising edge where
    // valid && ready; the source holds valid and payload stable until that edge.

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } stateT;

    stateT         state;
    stateT         nextState;
    logic [CW-1:0] settleCnt;
    logic          lastGrant;
    logic          curId;
    logic          anyReq;
    logic          grantId;
    logic          accept;

    assign dbgState = state;

    always_comb begin
        anyReq     = req0_valid | req1_valid;
        // Tie goes to the requester not served last; otherwise the sole requester wins.
        grantId    = (req0_valid && req1_valid) ? ~lastGrant : req1_valid;
        nextState  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (anyReq) begin
                    accept     = 1'b1;
                    req0_ready = ~grantId;
                    req1_ready = grantId;
                    nextState  = SETTLE;
                end
            end
            SETTLE: begin
                if (settleCnt == '0) nextState = RESP;
            end
            RESP: begin
                if (rsp_ready) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nextState;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settleCnt    <= '0;
            lastGrant    <= 1'b1;
            curId        <= 1'b0;
            au_a         <= '0;
            au_b         <= '0;
            au_carryIn   <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        au_a       <= grantId ? req1_a   : req0_a;
                        au_b       <= grantId ? req1_b   : req0_b;
                        au_carryIn <= grantId ? req1_sub : req0_sub;
                        lastGrant  <= grantId;
                        curId      <= grantId;
                        settleCnt  <= CW'(SETTLE_CYCLES - 1);
                    end
                end
                SETTLE: begin
                    // The ripple has had SETTLE_CYCLES edges to resolve when the count hits zero.
                    if (settleCnt == '0) begin
                        rsp_valid    <= 1'b1;
                        rsp_id       <= curId;
                        rsp_result   <= au_result;
                        rsp_carry    <= au_carryOut;
                        rsp_overflow <= au_overflow;
                    end else begin
                        settleCnt <= settleCnt - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Bench for addsub_share_arbiter: slow add/sub unit stand-in, arithmetic reference model,
// per-cycle compare process, directed scenarios and randomized two-requester traffic.
module tb_addsub_share_arbiter;

    localparam int W  = 64;
    localparam int SC = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req0_valid, req0_ready, req0_sub;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_sub;
    logic [W-1:0] req1_a, req1_b;
    logic [W-1:0] au_a, au_b, au_result;
    logic         au_carryIn, au_carryOut, au_overflow;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_overflow;
    logic [W-1:0] rsp_result;
    logic [1:0]   dbgState;

    int nChecks = 0;
    int nErrors = 0;

    addsub_share_arbiter #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .au_a(au_a), .au_b(au_b), .au_carryIn(au_carryIn),
        .au_result(au_result), .au_carryOut(au_carryOut), .au_overflow(au_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow),
        .dbgState(dbgState)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- add/sub unit stand-in ----------------
    // Outputs are wrong until just before the SC-th edge after the operands change.
    function automatic logic [W+1:0] unitCalc(input logic [W-1:0] a, b, input logic cin);
        logic [W-1:0] bb;
        logic [W:0]   s;
        logic         ov;
        bb = cin ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
        ov = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
        return {s[W], ov, s[W-1:0]};
    endfunction

    initial begin
        au_result = '0; au_carryOut = 1'b0; au_overflow = 1'b0;
    end

    always begin
        logic [W+1:0] r;
        @(au_a or au_b or au_carryIn);
        r = unitCalc(au_a, au_b, au_carryIn);
        au_result   = r[W-1:0] ^ 64'hA5A5_5A5A_C3C3_3C3C;
        au_carryOut = ~r[W+1];
        au_overflow = ~r[W];
        #(SC*10 - 3);
        {au_carryOut, au_overflow, au_result} = unitCalc(au_a, au_b, au_carryIn);
    end

    // ---------------- reference model + scoreboard ----------------
    // Packed expectation: {id, carry, overflow, result}
    function automatic logic [W+2:0] expOf(input logic id, input logic [W-1:0] a, b, input logic sub);
        logic [W:0]   full;
        logic [W-1:0] res;
        logic         c, ov;
        if (!sub) begin
            full = {1'b0, a} + {1'b0, b};
            res  = full[W-1:0];
            c    = full[W];
            ov   = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
        end else begin
            res = a - b;
            c   = (a >= b);
            ov  = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
        end
        return {id, c, ov, res};
    endfunction

    logic [W+2:0] exp_q[$];
    int           mMode = 0;   // 0 idle, 1 operation in flight, 2 response offered
    int           mWait = 0;
    logic         mLast = 1'b1;
    bit           idLog[$];

    always @(negedge clk) begin
        logic e0, e1;
        if (!reset_n) begin
            mMode = 0; mWait = 0; mLast = 1'b1;
            exp_q.delete();
        end else begin
            e0 = 1'b0; e1 = 1'b0;
            if (mMode == 0) begin
                if (req0_valid && req1_valid) begin
                    if (mLast) e0 = 1'b1; else e1 = 1'b1;
                end else if (req0_valid) e0 = 1'b1;
                else if (req1_valid)     e1 = 1'b1;
            end
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
            chk("ready_excl", req0_ready & req1_ready, 1'b0);
            chk("rsp_valid", rsp_valid, mMode == 2);
            if (mMode == 2 && exp_q.size() > 0)
                chk("rsp_fields", {rsp_id, rsp_carry, rsp_overflow, rsp_result}, exp_q[0]);
            case (mMode)
                0: if (e0 || e1) begin
                    if (e0) exp_q.push_back(expOf(1'b0, req0_a, req0_b, req0_sub));
                    else    exp_q.push_back(expOf(1'b1, req1_a, req1_b, req1_sub));
                    mLast = e1; mMode = 1; mWait = SC;
                end
                1: begin
                    mWait--;
                    if (mWait == 0) mMode = 2;
                end
                default: if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    mMode = 0;
                end
            endcase
            if (rsp_valid && rsp_ready) idLog.push_back(rsp_id);
        end
    end

    // ---------------- drivers ----------------
    int rspMode = 0;   // 0 always ready, 1 random, 2 manual
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rspMode == 0)      rsp_ready = 1'b1;
            else if (rspMode == 1) rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic issue(input bit id, input logic [W-1:0] a, b, input logic sub);
        bit got = 0;
        if (!id) begin req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1; end
        else     begin req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1; end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) begin got = 1; break; end
        end
        if (got) begin @(posedge clk); #1; end
        else chk("issue_timeout", 0, 1);
        if (!id) begin req0_valid = 1'b0; req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom}; end
        else     begin req1_valid = 1'b0; req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom}; end
    endtask

    task automatic waitIdle();
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (mMode == 0 && exp_q.size() == 0 && !rsp_valid) begin ok = 1; break; end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    task automatic waitRsp(output int lat);
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin lat = i; break; end
        end
        if (lat < 0) chk("rsp_timeout", 0, 1);
    endtask

    task automatic resetChecks();
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rsp_result", rsp_result, '0);
        chk("rst_rsp_flags", {rsp_carry, rsp_overflow}, 2'b00);
        chk("rst_au", {au_carryIn, au_a, au_b}, '0);
        chk("rst_readies", {req0_ready, req1_ready}, 2'b00);
    endtask

    task automatic doReset();
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1 resetChecks();
        @(posedge clk); #2;
        reset_n = 1'b1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic randReq(input bit id, input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            issue(id, pick(), pick(), 1'($urandom_range(0, 1)));
        end
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int           lat;
        logic [W+2:0] snap;
        bit           t5done;
        reset_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetChecks();
        @(posedge clk); #2 reset_n = 1'b1;

        chk("model_pin_add", expOf(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0),
            {1'b1, 1'b0, 1'b1, 64'h8000_0000_0000_0000});
        chk("model_pin_sub", expOf(1'b0, 64'd0, 64'd1, 1'b1), {1'b0, 1'b0, 1'b0, {W{1'b1}}});

        // 1: 500-500 from req0
        issue(0, 64'd500, 64'd500, 1'b1);
        waitRsp(lat);
        chk("t1_latency", lat, SC);
        chk("t1_rsp", {rsp_id, rsp_carry, rsp_overflow, rsp_result}, {1'b0, 1'b1, 1'b0, 64'd0});
        waitIdle();

        // 2: 500-150 from req1
        issue(1, 64'd500, 64'd150, 1'b1);
        waitRsp(lat);
        chk("t2_rsp", {rsp_id, rsp_carry, rsp_overflow, rsp_result}, {1'b1, 1'b1, 1'b0, 64'd350});
        waitIdle();

        // 3: signed overflow and borrow
        issue(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        waitRsp(lat);
        chk("t3a_rsp", {rsp_id, rsp_carry, rsp_overflow, rsp_result}, {1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_0000});
        waitIdle();
        issue(0, 64'd0, 64'd1, 1'b1);
        waitRsp(lat);
        chk("t3b_rsp", {rsp_id, rsp_carry, rsp_overflow, rsp_result}, {1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
        waitIdle();

        // 4: both requesters continuously busy right after reset
        doReset();
        idLog.delete();
        fork
            begin issue(0, 64'd10, 64'd3, 1'b0); issue(0, 64'd20, 64'd4, 1'b1); end
            begin issue(1, 64'd30, 64'd5, 1'b0); issue(1, 64'd40, 64'd6, 1'b1); end
        join
        waitIdle();
        if (idLog.size() == 4) chk("t4_order", {idLog[0], idLog[1], idLog[2], idLog[3]}, 4'b0101);
        else                   chk("t4_count", idLog.size(), 4);

        // 5: response back-pressure
        rspMode = 2; rsp_ready = 1'b0;
        issue(1, 64'd900, 64'd1000, 1'b1);
        waitRsp(lat);
        chk("t5_rsp", {rsp_id, rsp_carry, rsp_overflow, rsp_result}, {1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C});
        snap = {rsp_id, rsp_carry, rsp_overflow, rsp_result};
        t5done = 0;
        fork
            begin issue(0, 64'd11, 64'd22, 1'b0); t5done = 1; end
        join_none
        repeat (10) begin
            @(negedge clk);
            chk("t5_hold", {rsp_id, rsp_carry, rsp_overflow, rsp_result}, snap);
            chk("t5_valid_hold", rsp_valid, 1'b1);
            chk("t5_readies", {req0_ready, req1_ready}, 2'b00);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1; rspMode = 0;
        @(posedge clk); #1;
        chk("t5_consumed", rsp_valid, 1'b0);
        for (int i = 0; i < 300 && !t5done; i++) @(posedge clk);
        chk("t5_followup_done", t5done, 1'b1);
        #1 waitIdle();

        // 6: reset in the middle of an operation
        issue(0, 64'd5, 64'd3, 1'b0);
        waitIdle();
        issue(0, 64'd123, 64'd45, 1'b0);
        @(posedge clk);
        doReset();
        repeat (10) begin
            @(negedge clk);
            chk("t6_no_rsp", rsp_valid, 1'b0);
        end
        @(posedge clk); #1;
        idLog.delete();
        fork
            issue(0, 64'd1, 64'd2, 1'b0);
            issue(1, 64'd3, 64'd4, 1'b0);
        join
        waitIdle();
        chk("t6_tie_first", (idLog.size() > 0) ? idLog[0] : 1'b1, 1'b0);

        // randomized traffic with random back-pressure
        rspMode = 1;
        fork
            randReq(0, 15);
            randReq(1, 15);
        join
        rspMode = 0;
        waitIdle();

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
